// File: rtl/vproc_pkg.sv
// Shared vector-processor types and sizes used by the vector memory controller.
package vproc_pkg;

  localparam int unsigned VLEN_BITS  = 512;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MEM_ADDR_W = 9;
  localparam int unsigned MEM_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT,
    RESP
  } vmem_state_t;

  // One requester's operation as seen by the memory side
  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [VLEN_BITS-1:0]  wdata;
  } vmem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above prio, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    prio,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(prio) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// Shares the single-port vector memory between requesters, one transaction at a time,
// and returns a tagged response per transaction.
module vmem_arbiter
  import vproc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clock,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*MEM_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*VLEN_BITS-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            mem_wr_enable,
  output logic                            mem_rd_enable,
  output logic [MEM_ADDR_W-1:0]           mem_addr,
  output logic [VLEN_BITS-1:0]            mem_wr_data,
  input  logic [VLEN_BITS-1:0]            mem_rd_data,
  output logic                            rsp_valid,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_write,
  output logic [VLEN_BITS-1:0]            rsp_rdata,
  output logic                            busy
);

  vmem_state_t          state_q, state_d;
  logic [ID_W-1:0]      prio_q, prio_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic                 op_write_q, op_write_d;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  vmem_req_t            win;

  logic [NUM_REQ-1:0]   req_ready_d;
  logic                 wr_en_d, rd_en_d;
  logic [MEM_ADDR_W-1:0] addr_d;
  logic [VLEN_BITS-1:0] wdata_d;
  logic                 rsp_valid_d, rsp_write_d, busy_d;
  logic [ID_W-1:0]      rsp_id_d;
  logic [VLEN_BITS-1:0] rdata_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req      (req_valid),
    .prio     (prio_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Unpack the winning requester's payload
  always_comb begin
    win.write = req_write[grant_id];
    win.addr  = req_addr[32'(grant_id)*MEM_ADDR_W +: MEM_ADDR_W];
    win.wdata = req_wdata[32'(grant_id)*VLEN_BITS +: VLEN_BITS];
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    op_write_d  = op_write_q;
    req_ready_d = '0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = mem_addr;
    wdata_d     = mem_wr_data;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_write_d = 1'b0;
    rdata_d     = rsp_rdata;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d     = ACCESS;
          req_ready_d = grant;
          owner_d     = grant_id;
          op_write_d  = win.write;
          addr_d      = win.addr;
          wdata_d     = win.wdata;
          wr_en_d     = win.write;
          rd_en_d     = !win.write;
          prio_d      = (32'(grant_id) == NUM_REQ - 1) ? '0 : ID_W'(32'(grant_id) + 1);
          if (win.write) rdata_d = '0;
        end
      end
      ACCESS:  state_d = op_write_q ? RESP : RD_WAIT;
      RD_WAIT: begin
        rdata_d = mem_rd_data;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = owner_q;
        rsp_write_d = op_write_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prio_q        <= '0;
      owner_q       <= '0;
      op_write_q    <= 1'b0;
      req_ready     <= '0;
      mem_wr_enable <= 1'b0;
      mem_rd_enable <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      op_write_q    <= op_write_d;
      req_ready     <= req_ready_d;
      mem_wr_enable <= wr_en_d;
      mem_rd_enable <= rd_en_d;
      mem_addr      <= addr_d;
      mem_wr_data   <= wdata_d;
      rsp_valid     <= rsp_valid_d;
      rsp_id        <= rsp_id_d;
      rsp_write     <= rsp_write_d;
      rsp_rdata     <= rdata_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter with a behavioural 512x32 single-port memory.
module tb_vmem_arbiter;

  localparam int unsigned N = 2;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*9-1:0]    req_addr;
  logic [N*512-1:0]  req_wdata;
  logic [N-1:0]      req_ready;
  logic              mem_wr_enable;
  logic              mem_rd_enable;
  logic [8:0]        mem_addr;
  logic [511:0]      mem_wr_data;
  logic [511:0]      mem_rd_data;
  logic              rsp_valid;
  logic [0:0]        rsp_id;
  logic              rsp_write;
  logic [511:0]      rsp_rdata;
  logic              busy;

  logic              preload;
  logic [31:0]       mem [512];

  int checks   = 0;
  int failures = 0;

  vmem_arbiter #(.NUM_REQ(N)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .mem_wr_enable (mem_wr_enable),
    .mem_rd_enable (mem_rd_enable),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Synchronous memory: 16 consecutive words, address wraps at 512
  always @(posedge clock) begin
    if (preload) begin
      for (int n = 0; n < 512; n++) mem[n] <= 32'(n);
    end else if (mem_wr_enable) begin
      for (int k = 0; k < 16; k++) mem[9'(32'(mem_addr) + k)] <= mem_wr_data[32*k +: 32];
    end
    if (mem_rd_enable) begin
      for (int k = 0; k < 16; k++) mem_rd_data[32*k +: 32] <= mem[9'(32'(mem_addr) + k)];
    end
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and check grant, memory strobe and the tagged response
  task automatic do_txn(input int i, input logic wr, input logic [8:0] a,
                        input logic [511:0] wd, input logic [511:0] exp_rd,
                        input int exp_lat, input string tag);
    int n;
    req_write[i]           = wr;
    req_addr[9*i +: 9]     = a;
    req_wdata[512*i +: 512] = wd;
    req_valid[i]           = 1'b1;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 16) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_ready"}, 512'(req_ready[i]), 512'(1));
    check_eq({tag, "_en"}, 512'({mem_wr_enable, mem_rd_enable}), 512'(wr ? 2'b10 : 2'b01));
    check_eq({tag, "_addr"}, 512'(mem_addr), 512'(a));
    if (wr) check_eq({tag, "_wdata"}, mem_wr_data, wd);
    req_valid[i] = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rsp_valid !== 1'b1 && n < 10);
    check_eq({tag, "_lat"}, 512'(n), 512'(exp_lat));
    check_eq({tag, "_id"}, 512'(rsp_id), 512'(i));
    check_eq({tag, "_rw"}, 512'(rsp_write), 512'(wr));
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rd);
  endtask

  initial begin
    logic [511:0] wd1, exp_wrap, exp_505;
    logic [4:0]   acc;
    logic         pb, lastwe, dbl;
    int           n, g;
    int           tr [3];

    for (int k = 0; k < 16; k++) begin
      wd1[32*k +: 32]      = 32'(k + 1);
      exp_wrap[32*k +: 32] = 32'((504 + k) % 512);
      exp_505[32*k +: 32]  = 32'((505 + k) % 512);
    end

    rst_n     = 1'b0;
    preload   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_ctrl", 512'({req_ready, mem_wr_enable, mem_rd_enable, rsp_valid, rsp_write, busy}), 512'(0));
    check_eq("rst_addr_id", 512'({mem_addr, rsp_id}), 512'(0));
    check_eq("rst_wdata", mem_wr_data, 512'(0));
    check_eq("rst_rdata", rsp_rdata, 512'(0));
    rst_n = 1'b1;

    // Idle stability
    acc = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      acc = acc | {mem_wr_enable, mem_rd_enable, rsp_valid, busy, |req_ready};
    end
    check_eq("idle_quiet", 512'(acc), 512'(0));

    // Contention from reset: both requesters hold writes, expect 0,1,0,1
    req_write         = 2'b11;
    req_addr[0 +: 9]  = 9'h040;
    req_addr[9 +: 9]  = 9'h080;
    req_wdata         = {wd1, wd1};
    req_valid         = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n  = 0;
      pb = busy;
      while (req_ready == '0 && n < 10) begin
        pb = busy;
        @(negedge clock);
        n++;
      end
      check_eq("cont_grant", 512'(req_ready), 512'((k % 2) ? 2'b10 : 2'b01));
      check_eq("cont_notbusy", 512'(pb), 512'(0));
      if (k == 3) req_valid = '0;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (rsp_valid !== 1'b1 && n < 10);
      check_eq("cont_rspid", 512'(rsp_id), 512'(k % 2));
    end

    // Single write then read back
    do_txn(0, 1'b1, 9'h010, wd1, 512'(0), 2, "wr0");
    do_txn(0, 1'b0, 9'h010, 512'(0), wd1, 3, "rd0");

    // Back-to-back writes from requester 1
    req_write[1]      = 1'b1;
    req_addr[9 +: 9]  = 9'h100;
    req_valid[1]      = 1'b1;
    g      = 0;
    lastwe = 1'b0;
    dbl    = 1'b0;
    tr     = '{-100, -200, -300};
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (mem_wr_enable && lastwe) dbl = 1'b1;
      lastwe = mem_wr_enable;
      if (req_ready[1]) begin
        if (g < 3) tr[g] = c;
        g++;
        if (g == 3) req_valid[1] = 1'b0;
        else req_addr[9 +: 9] = req_addr[9 +: 9] + 9'h010;
      end
    end
    check_eq("b2b_count", 512'(g), 512'(3));
    check_eq("b2b_gap01", 512'(tr[1] - tr[0]), 512'(3));
    check_eq("b2b_gap12", 512'(tr[2] - tr[1]), 512'(3));
    check_eq("b2b_wedbl", 512'(dbl), 512'(0));

    // Wrapping reads against a preloaded word n = n image
    preload = 1'b1;
    @(negedge clock);
    preload = 1'b0;
    do_txn(0, 1'b0, 9'h1F8, 512'(0), exp_wrap, 3, "rdwrap");
    do_txn(1, 1'b0, 9'd505, 512'(0), exp_505, 3, "rd505");

    // Reset during RD_WAIT drops the read; pending req1 wins afterwards
    req_write[0]     = 1'b0;
    req_addr[0 +: 9] = 9'h000;
    req_valid[0]     = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 16) begin
      @(negedge clock);
      n++;
    end
    check_eq("mrst_ready", 512'(req_ready[0]), 512'(1));
    req_valid[0] = 1'b0;
    @(negedge clock);
    req_write[1]     = 1'b1;
    req_addr[9 +: 9] = 9'h020;
    req_valid[1]     = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_ctrl", 512'({req_ready, mem_wr_enable, mem_rd_enable, rsp_valid, rsp_write, busy, mem_addr, rsp_id}), 512'(0));
    check_eq("mrst_data", 512'({mem_wr_data, rsp_rdata}), 512'(0));
    pb = 1'b0;
    repeat (3) begin
      @(negedge clock);
      pb = pb | rsp_valid;
    end
    check_eq("mrst_norsp", 512'(pb), 512'(0));
    rst_n = 1'b1;
    @(negedge clock);
    check_eq("mrst_grant1", 512'(req_ready), 512'(2'b10));
    req_valid = '0;
    repeat (5) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
